// File: rtl/swipt_lock_ctrl.sv
// SWIPT acquisition/lock sequencer: settle, stepped frequency sweep with edge-count lock detect, PLL tracking.
// Optional SWIPT_AUTORETRY_EN: FAIL re-enters SETTLE after RETRY_CYC cycles instead of waiting for swiptAlive to drop.
module swipt_lock_ctrl #(
  parameter logic [31:0] F_DEFAULT  = 32'hA410,
  parameter logic [31:0] F_MIN      = 32'h9C40,
  parameter logic [31:0] F_MAX      = 32'hAFC8,
  parameter logic [31:0] F_STEP     = 32'h1F4,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned DWELL_CYC  = 256,
  parameter int unsigned EDGE_MIN   = 4,
  parameter int unsigned LOSS_CYC   = 4096
`ifdef SWIPT_AUTORETRY_EN
  ,
  parameter int unsigned RETRY_CYC  = 100000
`endif
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic        link,
  input  logic [31:0] f_pll,
  output logic [31:0] freq,
  output logic        freq_rdy,
  output logic        locked,
  output logic        sweep_fail,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SWEEP  = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_TRACK  = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic [2:0]  r_state, w_next;
  logic [31:0] r_freq, r_cnt, r_loss_cnt;
  logic [7:0]  r_edge_cnt;
  logic        r_link_d, r_freq_rdy, r_locked, r_sweep_fail;
  logic        w_freq_rdy, w_locked, w_sweep_fail;
  logic        w_rise, w_edges_ok, w_dwell_end, w_step_ovf, w_pll_bad, w_loss, w_cnt_run;
  logic [8:0]  w_edge_total;
  logic [32:0] w_step_sum;

  assign w_rise       = link & ~r_link_d;
  // A rise in the last dwell cycle still counts towards the decision.
  assign w_edge_total = {1'b0, r_edge_cnt} + {8'd0, w_rise};
  assign w_edges_ok   = 32'(w_edge_total) >= EDGE_MIN;
  assign w_dwell_end  = r_cnt == DWELL_CYC - 1;
  assign w_step_sum   = {1'b0, r_freq} + {1'b0, F_STEP};
  assign w_step_ovf   = w_step_sum > {1'b0, F_MAX};
  assign w_pll_bad    = (f_pll < F_MIN) || (f_pll > F_MAX);
  assign w_loss       = w_pll_bad || (!w_rise && (r_loss_cnt == LOSS_CYC - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_freq_rdy   <= 1'b1;
      r_locked     <= 1'b0;
      r_sweep_fail <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_freq_rdy   <= w_freq_rdy;
      r_locked     <= w_locked;
      r_sweep_fail <= w_sweep_fail;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && !swiptAlive) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (swiptAlive) w_next = S_SETTLE;
        S_SETTLE: if (r_cnt == SETTLE_CYC - 1) w_next = S_SWEEP;
        S_SWEEP:  w_next = S_DWELL;
        S_DWELL: begin
          if (w_dwell_end) begin
            if (w_edges_ok)      w_next = S_TRACK;
            else if (w_step_ovf) w_next = S_FAIL;
            else                 w_next = S_SWEEP;
          end
        end
        S_TRACK:  if (w_loss) w_next = S_SWEEP;
        S_FAIL: begin
`ifdef SWIPT_AUTORETRY_EN
          if (r_cnt == RETRY_CYC - 1) w_next = S_SETTLE;
`endif
        end
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_freq_rdy   = (w_next != S_TRACK);
    w_locked     = (w_next == S_TRACK);
    w_sweep_fail = (w_next == S_FAIL);
  end

  // Shared cycle counter: settle, dwell and (when enabled) retry timing.
  assign w_cnt_run = (w_next == r_state) && ((r_state == S_SETTLE) || (r_state == S_DWELL)
`ifdef SWIPT_AUTORETRY_EN
                     || (r_state == S_FAIL)
`endif
                     );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_freq     <= F_DEFAULT;
      r_cnt      <= 32'd0;
      r_edge_cnt <= 8'd0;
      r_loss_cnt <= 32'd0;
      r_link_d   <= 1'b0;
    end else begin
      r_link_d <= link;
      r_cnt    <= w_cnt_run ? r_cnt + 32'd1 : 32'd0;

      if (r_state == S_DWELL && w_next == S_DWELL)
        r_edge_cnt <= (r_edge_cnt == 8'hFF) ? r_edge_cnt : r_edge_cnt + {7'd0, w_rise};
      else
        r_edge_cnt <= 8'd0;

      if (r_state == S_TRACK && w_next == S_TRACK)
        r_loss_cnt <= w_rise ? 32'd0 : r_loss_cnt + 32'd1;
      else
        r_loss_cnt <= 32'd0;

      if (w_next == S_IDLE || w_next == S_FAIL)
        r_freq <= F_DEFAULT;
      else if (w_next == S_SWEEP)
        r_freq <= (r_state == S_DWELL) ? w_step_sum[31:0] : F_MIN;
      else if (r_state == S_TRACK && w_next == S_TRACK)
        r_freq <= f_pll;
    end
  end

  assign freq       = r_freq;
  assign freq_rdy   = r_freq_rdy;
  assign locked     = r_locked;
  assign sweep_fail = r_sweep_fail;
  assign state      = r_state;

endmodule

// File: tb/tb_swipt_lock_ctrl.sv
// Bench for swipt_lock_ctrl: directed plan scenarios plus randomized stimulus, checked every cycle
// against a sweep-index reference model.
module tb_swipt_lock_ctrl;

  localparam int F_DEF   = 'hA410;
  localparam int F_MIN   = 'h9C40;
  localparam int F_MAX   = 'hAFC8;
  localparam int F_STEP  = 'h1F4;
  localparam int P_SETTLE = 16;
  localparam int P_DWELL  = 32;
  localparam int P_EDGE   = 4;
  localparam int P_LOSS   = 64;
`ifdef SWIPT_AUTORETRY_EN
  localparam int P_RETRY  = 50;
`endif

  localparam int S_IDLE = 0, S_SETTLE = 1, S_SWEEP = 2, S_DWELL = 3, S_TRACK = 4, S_FAIL = 5;

  logic        clk, nrst, swiptAlive, link;
  logic [31:0] f_pll;
  logic [31:0] freq;
  logic        freq_rdy, locked, sweep_fail;
  logic [2:0]  state;

  swipt_lock_ctrl #(
    .SETTLE_CYC(P_SETTLE),
    .DWELL_CYC (P_DWELL),
    .EDGE_MIN  (P_EDGE),
    .LOSS_CYC  (P_LOSS)
`ifdef SWIPT_AUTORETRY_EN
    ,
    .RETRY_CYC (P_RETRY)
`endif
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .swiptAlive(swiptAlive),
    .link      (link),
    .f_pll     (f_pll),
    .freq      (freq),
    .freq_rdy  (freq_rdy),
    .locked    (locked),
    .sweep_fail(sweep_fail),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mode    = 0;
  logic [31:0] target = 32'h0;

  // Reference model: sweep point index, time spent in the current phase, edges seen, quiet time.
  int          m_st = S_IDLE, m_t = 0, m_idx = 0, m_edges = 0, m_quiet = 0;
  logic [31:0] m_freq = 32'(F_DEF);
  bit          m_link_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic go_idle();
    m_st = S_IDLE; m_t = 0; m_edges = 0; m_quiet = 0; m_idx = 0; m_freq = 32'(F_DEF);
  endtask

  task automatic model_next();
    bit rise;
    rise = link && !m_link_d;
    if (!nrst) begin
      go_idle();
      m_link_d = 1'b0;
      return;
    end
    m_link_d = link;
    if (m_st != S_IDLE && !swiptAlive) begin
      go_idle();
      return;
    end
    case (m_st)
      S_IDLE: if (swiptAlive) begin m_st = S_SETTLE; m_t = 0; end
      S_SETTLE: begin
        m_t++;
        if (m_t == P_SETTLE) begin m_st = S_SWEEP; m_idx = 0; m_freq = 32'(F_MIN); end
      end
      S_SWEEP: begin m_st = S_DWELL; m_t = 0; m_edges = 0; end
      S_DWELL: begin
        m_t++;
        if (rise && m_edges < 255) m_edges++;
        if (m_t == P_DWELL) begin
          if (m_edges >= P_EDGE) begin
            m_st = S_TRACK; m_quiet = 0;
          end else if (longint'(F_MIN) + longint'(m_idx + 1) * longint'(F_STEP) > longint'(F_MAX)) begin
            m_st = S_FAIL; m_t = 0; m_freq = 32'(F_DEF);
          end else begin
            m_idx++; m_st = S_SWEEP; m_freq = 32'(F_MIN + m_idx * F_STEP);
          end
        end
      end
      S_TRACK: begin
        m_quiet = rise ? 0 : m_quiet + 1;
        if (f_pll < F_MIN || f_pll > F_MAX || m_quiet == P_LOSS) begin
          m_st = S_SWEEP; m_idx = 0; m_freq = 32'(F_MIN);
        end else begin
          m_freq = f_pll;
        end
      end
      S_FAIL: begin
`ifdef SWIPT_AUTORETRY_EN
        m_t++;
        if (m_t == P_RETRY) begin m_st = S_SETTLE; m_t = 0; end
`endif
      end
      default: go_idle();
    endcase
  endtask

  // One clock: drive link on the falling edge, advance the model, compare just after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    case (mode)
      0:       link = 1'b0;
      1:       link = (m_freq == target) ? cyc[2] : 1'b0;
      2:       link = cyc[2];
      default: link = 1'($urandom % 2);
    endcase
    model_next();
    @(posedge clk);
    #1;
    chk("state", {29'd0, state}, 32'(m_st));
    chk("freq", freq, m_freq);
    chk("freq_rdy", {31'd0, freq_rdy}, {31'd0, m_st != S_TRACK});
    chk("locked", {31'd0, locked}, {31'd0, m_st == S_TRACK});
    chk("sweep_fail", {31'd0, sweep_fail}, {31'd0, m_st == S_FAIL});
  endtask

  task automatic run_until(input int st, input int min_t, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!(m_st == st && m_t >= min_t) && n < max_cyc) begin
      step();
      n++;
    end
    if (!(m_st == st && m_t >= min_t)) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout %s: model state %0d, wanted %0d", tag, m_st, st);
    end
  endtask

  initial begin
    nrst = 1'b0; swiptAlive = 1'b1; link = 1'b0; f_pll = 32'hA100; mode = 0;
    repeat (3) step();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_freq", freq, 32'hA410);
    chk("rst_rdy", {31'd0, freq_rdy}, 32'd1);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    nrst = 1'b1;
    step();
    chk("settle_after_rst", {29'd0, state}, 32'd1);

    // Lock only at the third sweep point, then lose it once link goes quiet.
    mode = 1; target = 32'hA028;
    run_until(S_TRACK, 0, 400, "lock_a028");
    chk("lock_freq_hold", freq, 32'hA028);
    chk("lock_rdy", {31'd0, freq_rdy}, 32'd0);
    step();
    chk("track_follow", freq, 32'hA100);
    run_until(S_SWEEP, 0, 200, "loss_quiet");
    chk("loss_freq", freq, 32'h9C40);
    chk("loss_locked", {31'd0, locked}, 32'd0);

    // f_pll out of range forces an immediate re-sweep.
    mode = 2;
    run_until(S_TRACK, 0, 400, "lock_toggle");
    f_pll = 32'hB000;
    step();
    chk("pll_range_loss", {29'd0, state}, 32'd2);
    f_pll = 32'hA100;

    // swiptAlive drops mid-DWELL and mid-TRACK.
    run_until(S_DWELL, 10, 200, "mid_dwell");
    swiptAlive = 1'b0;
    step();
    chk("drop_dwell_state", {29'd0, state}, 32'd0);
    chk("drop_dwell_freq", freq, 32'hA410);
    swiptAlive = 1'b1;
    run_until(S_TRACK, 0, 400, "relock");
    repeat (5) step();
    swiptAlive = 1'b0;
    step();
    chk("drop_track_state", {29'd0, state}, 32'd0);
    chk("drop_track_freq", freq, 32'hA410);

    // No edges at all: every sweep point fails.
    mode = 0; swiptAlive = 1'b1;
    run_until(S_FAIL, 0, 1000, "sweep_fail");
    chk("fail_flag", {31'd0, sweep_fail}, 32'd1);
    chk("fail_freq", freq, 32'hA410);
    chk("fail_rdy", {31'd0, freq_rdy}, 32'd1);
    repeat (60) step();
`ifdef SWIPT_AUTORETRY_EN
    chk("retry_state", {29'd0, state}, 32'd1);
    chk("retry_flag", {31'd0, sweep_fail}, 32'd0);
`else
    chk("fail_sticky", {29'd0, state}, 32'd5);
`endif

    // Randomized blocks: link style, lock point, PLL estimate, occasional alive drops and resets.
    for (int blk = 0; blk < 30; blk++) begin
      int len;
      mode   = int'($urandom % 4);
      target = 32'(F_MIN + int'($urandom % 11) * F_STEP);
      f_pll  = 32'(F_MIN) + ($urandom % 32'(F_MAX - F_MIN + 1));
      if ($urandom % 4 == 0) f_pll = $urandom;
      len = 100 + int'($urandom % 400);
      for (int k = 0; k < len; k++) begin
        swiptAlive = ($urandom % 150) != 0;
        nrst       = ($urandom % 600) != 0;
        step();
      end
    end
    nrst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
